// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one multi-cycle multiplier among four requesters.
// Requests are served round-robin. The winner's operands are captured at grant.
// After LATENCY cycles a registered product and a one-cycle Done strobe are
// returned to the winner.
module mul_share_arbiter #(
    parameter int DATAWIDTH = 64,
    parameter int LATENCY   = 3
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [3:0]             Req,
    input  logic [4*DATAWIDTH-1:0] A,
    input  logic [4*DATAWIDTH-1:0] B,
    output logic [3:0]             Grant,
    output logic [3:0]             Done,
    output logic [DATAWIDTH-1:0]   Prod,
    output logic                   Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1 at grant. EXEC therefore spans
    // exactly LATENCY clock edges before Done is raised.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                 state_reg, state_next;
    logic [1:0]             ptr_reg, ptr_next;
    logic [1:0]             own_reg, own_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [DATAWIDTH-1:0]   opa_reg, opa_next;
    logic [DATAWIDTH-1:0]   opb_reg, opb_next;
    logic [3:0]             grant_reg, grant_next;
    logic [3:0]             done_reg, done_next;
    logic [DATAWIDTH-1:0]   prod_reg, prod_next;

    logic [DATAWIDTH-1:0]   a_arr [4];
    logic [DATAWIDTH-1:0]   b_arr [4];
    logic [1:0]             cand_idx [4];
    logic [3:0]             cand_hit;
    logic [1:0]             sel_idx;
    logic [DATAWIDTH-1:0]   mul_res;

    // Unpack the operand buses.
    // Rotate the request vector so that offset 0 is the current pointer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign a_arr[gi]    = A[gi*DATAWIDTH +: DATAWIDTH];
            assign b_arr[gi]    = B[gi*DATAWIDTH +: DATAWIDTH];
            assign cand_idx[gi] = ptr_reg + 2'(gi);
            assign cand_hit[gi] = Req[cand_idx[gi]];
        end
    endgenerate

    // Pick the first requester at or after the pointer, wrapping modulo 4.
    // The loop runs from the highest offset down, so the lowest hit is written last and wins.
    always_comb begin
        sel_idx = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand_hit[i]) begin
                sel_idx = cand_idx[i];
            end
        end
    end

    // The product is truncated to the low DATAWIDTH bits by the assignment width.
    assign mul_res = opa_reg * opb_reg;

    // State register. Reset discards any in-flight operation.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            own_reg   <= '0;
            cnt_reg   <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            prod_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            own_reg   <= own_next;
            cnt_reg   <= cnt_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            prod_reg  <= prod_next;
        end
    end

    // Next-state logic: grant in IDLE, count down in EXEC, release in DONE.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        own_next   = own_reg;
        cnt_next   = cnt_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        grant_next = grant_reg;
        done_next  = done_reg;
        prod_next  = prod_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|Req) begin
                    own_next   = sel_idx;
                    opa_next   = a_arr[sel_idx];
                    opb_next   = b_arr[sel_idx];
                    grant_next = 4'b0001 << sel_idx;
                    cnt_next   = CNT_INIT;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == 4'd0) begin
                    prod_next  = mul_res;
                    done_next  = grant_reg;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_DONE: begin
                done_next  = '0;
                grant_next = '0;
                ptr_next   = own_reg + 2'd1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Grant = grant_reg;
    assign Done  = done_reg;
    assign Prod  = prod_reg;
    assign Busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter with DATAWIDTH=8 and LATENCY=3.
// A table of directed operations is replayed first.
// Hand-written sequences then cover operand withdrawal and reset during EXEC.
module tb_mul_share_arbiter;

    localparam int DW  = 8;
    localparam int LAT = 3;

    logic            Clk;
    logic            rst_n;
    logic [3:0]      Req;
    logic [4*DW-1:0] A;
    logic [4*DW-1:0] B;
    logic [3:0]      Grant;
    logic [3:0]      Done;
    logic [DW-1:0]   Prod;
    logic            Busy;

    int total = 0;
    int bad   = 0;

    mul_share_arbiter #(.DATAWIDTH(DW), .LATENCY(LAT)) dut (
        .Clk   (Clk),
        .Rst   (rst_n),
        .Req   (Req),
        .A     (A),
        .B     (B),
        .Grant (Grant),
        .Done  (Done),
        .Prod  (Prod),
        .Busy  (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  g;
        logic [7:0]  p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run one full operation that starts from IDLE.
    // Every cycle is checked. The task consumes LAT+2 clock edges.
    task automatic run_op(input int id, input logic [3:0] req, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] g, input logic [7:0] p);
        Req = req; A = a; B = b;
        @(posedge Clk); #1;
        chk("grant", 32'(Grant), 32'(g));
        chk("busy_exec", 32'(Busy), 32'd1);
        chk("done_early", 32'(Done), 32'd0);
        for (int c = 1; c < LAT; c++) begin
            @(posedge Clk); #1;
            chk("done_early", 32'(Done), 32'd0);
            chk("grant_hold", 32'(Grant), 32'(g));
        end
        @(posedge Clk); #1;
        chk("done", 32'(Done), 32'(g));
        chk("grant_in_done", 32'(Grant), 32'(g));
        chk("prod", 32'(Prod), 32'(p));
        @(posedge Clk); #1;
        chk("done_clear", 32'(Done), 32'd0);
        chk("grant_clear", 32'(Grant), 32'd0);
        chk("busy_idle", 32'(Busy), 32'd0);
        chk("prod_hold", 32'(Prod), 32'(p));
        $display("op %0d req=%b grant=%b prod=%0d", id, req, g, Prod);
    endtask

    initial begin
        // Each 32-bit operand word packs four 8-bit slices as {slice3, slice2, slice1, slice0}.
        // Non-selected slices carry junk so that a wrong slice select changes the product.
        vecs[0] = '{4'b0100, {8'd99, 8'd12, 8'd77, 8'd55},  {8'd3, 8'd11, 8'd4, 8'd5},   4'b0100, 8'd132};
        vecs[1] = '{4'b0001, {8'd1, 8'd2, 8'd3, 8'd200},    {8'd9, 8'd9, 8'd9, 8'd3},    4'b0001, 8'd88};
        vecs[2] = '{4'b1000, {8'd15, 8'd1, 8'd1, 8'd1},     {8'd17, 8'd2, 8'd2, 8'd2},   4'b1000, 8'd255};
        vecs[3] = '{4'b1111, {8'd255, 8'd20, 8'd13, 8'd7},  {8'd255, 8'd20, 8'd5, 8'd9}, 4'b0001, 8'd63};
        vecs[4] = '{4'b1111, {8'd255, 8'd20, 8'd13, 8'd7},  {8'd255, 8'd20, 8'd5, 8'd9}, 4'b0010, 8'd65};
        vecs[5] = '{4'b1111, {8'd255, 8'd20, 8'd13, 8'd7},  {8'd255, 8'd20, 8'd5, 8'd9}, 4'b0100, 8'd144};
        vecs[6] = '{4'b1111, {8'd255, 8'd20, 8'd13, 8'd7},  {8'd255, 8'd20, 8'd5, 8'd9}, 4'b1000, 8'd1};
        vecs[7] = '{4'b1111, {8'd255, 8'd20, 8'd13, 8'd7},  {8'd255, 8'd20, 8'd5, 8'd9}, 4'b0001, 8'd63};

        Req = '0; A = '0; B = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_prod", 32'(Prod), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        repeat (2) @(posedge Clk);
        #1 rst_n = 1'b1;

        // Idle for ten cycles with no requests.
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            chk("idle_grant", 32'(Grant), 32'd0);
            chk("idle_done", 32'(Done), 32'd0);
            chk("idle_prod", 32'(Prod), 32'd0);
            chk("idle_busy", 32'(Busy), 32'd0);
        end
        $display("reset/idle sequence checked");

        // Directed table: single ops, truncation, then a round-robin sweep.
        for (int i = 0; i < 8; i++) begin
            run_op(i, vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].p);
        end

        // Requester 1 withdraws and changes its A operand during EXEC.
        // The pointer is now 1.
        Req = 4'b0010;
        A = {8'd1, 8'd1, 8'd30, 8'd1};
        B = {8'd1, 8'd1, 8'd4, 8'd1};
        @(posedge Clk); #1;
        chk("wd_grant", 32'(Grant), 32'b0010);
        A = {8'd1, 8'd1, 8'd99, 8'd1};
        Req = 4'b0000;
        for (int c = 1; c < LAT; c++) begin
            @(posedge Clk); #1;
            chk("wd_done_early", 32'(Done), 32'd0);
            chk("wd_grant_hold", 32'(Grant), 32'b0010);
        end
        @(posedge Clk); #1;
        chk("wd_done", 32'(Done), 32'b0010);
        chk("wd_prod", 32'(Prod), 32'd120);
        @(posedge Clk); #1;
        chk("wd_idle", 32'(Busy), 32'd0);
        $display("withdrawal op prod=%0d", Prod);

        // Reset during EXEC discards the operation.
        // The pointer must return to 0: it was 2 before the reset.
        Req = 4'b0100;
        A = {8'd1, 8'd5, 8'd1, 8'd1};
        B = {8'd1, 8'd6, 8'd1, 8'd1};
        @(posedge Clk); #1;
        chk("mr_grant", 32'(Grant), 32'b0100);
        @(posedge Clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mr_grant0", 32'(Grant), 32'd0);
        chk("mr_done0", 32'(Done), 32'd0);
        chk("mr_busy0", 32'(Busy), 32'd0);
        chk("mr_prod0", 32'(Prod), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            chk("mr_no_done", 32'(Done), 32'd0);
        end
        rst_n = 1'b1;
        $display("reset mid-exec checked");
        run_op(8, 4'b1111, {8'd255, 8'd20, 8'd13, 8'd7}, {8'd255, 8'd20, 8'd5, 8'd9}, 4'b0001, 8'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
